// File: rtl/twiddle_if.sv
// Twiddle stream from the sequencer to the twiddle multiplier.
// Valid/ready handshake plus the twiddle value and its stage/exponent tags.
interface twiddle_if #(
   parameter int N    = 64,
   parameter int TW_W = 10
);
   localparam int LOGN = $clog2(N);

   logic                     tw_valid;
   logic                     tw_ready;
   logic signed [TW_W-1:0]   w_r;
   logic signed [TW_W-1:0]   w_i;
   logic [$clog2(LOGN)-1:0]  tw_stage;
   logic [LOGN-2:0]          tw_k;
   logic                     tw_last;

   modport master (
      output tw_valid, w_r, w_i, tw_stage, tw_k, tw_last,
      input  tw_ready
   );

   modport slave (
      input  tw_valid, w_r, w_i, tw_stage, tw_k, tw_last,
      output tw_ready
   );
endinterface

// File: rtl/twiddle_seq.sv
// Twiddle-factor sequencer for the radix-2 DIF FFT: emits W_N^k stage by stage in
// butterfly order from a quarter-wave cosine table, with optional conjugation for the IFFT.
//
// state | meaning
// IDLE  | waiting for start, counters at zero
// RUN   | issuing indices into the three-stage pipeline
// FLUSH | last index issued, draining until tw_last is accepted
module twiddle_seq #(
   parameter int N    = 64,
   parameter int TW_W = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic inverse,
   output logic busy,
   output logic done,
   twiddle_if.master tw
);

   localparam int LOGN = $clog2(N);
   localparam int S_W  = $clog2(LOGN);
   localparam int K_W  = LOGN - 1;
   localparam int A_W  = LOGN - 2;
   localparam int Q    = N / 4;
   localparam int FRAC = 28;

   // Cosine table C[0..N/4] built at elaboration with fixed-point Taylor series,
   // rounded half away from zero to TW_W bits with 2 integer bits.
   function automatic logic [(Q+1)*TW_W-1:0] build_rom();
      logic [(Q+1)*TW_W-1:0] img;
      longint x, x2, term, acc, v;
      img = '0;
      for (int i = 0; i <= Q; i++) begin
         x    = (longint'(i) * 64'sd1686629713) / longint'(N);
         x2   = (x * x) >>> FRAC;
         term = 64'sd1 <<< FRAC;
         acc  = term;
         for (int n = 1; n <= 12; n++) begin
            term = -((term * x2) >>> FRAC) / longint'((2*n - 1) * (2*n));
            acc  = acc + term;
         end
         v = acc * (64'sd1 <<< (TW_W - 2));
         if (v >= 0) v = (v + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
         else        v = -((-v + (64'sd1 <<< (FRAC - 1))) >>> FRAC);
         img[i*TW_W +: TW_W] = v[TW_W-1:0];
      end
      return img;
   endfunction

   localparam logic [(Q+1)*TW_W-1:0] ROM_IMG = build_rom();

   function automatic logic signed [TW_W-1:0] rom_rd(input logic [A_W:0] idx);
      return ROM_IMG[int'(idx)*TW_W +: TW_W];
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t              state;
   logic [S_W-1:0]      s_cnt;
   logic [K_W-1:0]      b_cnt;
   logic                inv_q;

   logic                en, cnt_last, issue;
   logic [K_W-1:0]      k_mask, k_next;

   logic                p0_valid, p0_quad, p0_inv, p0_last;
   logic [S_W-1:0]      p0_stage;
   logic [K_W-1:0]      p0_k;
   logic [A_W-1:0]      p0_a;

   logic                p1_valid, p1_quad, p1_inv, p1_last;
   logic [S_W-1:0]      p1_stage;
   logic [K_W-1:0]      p1_k;
   logic signed [TW_W-1:0] rom_x, rom_y;

   logic signed [TW_W-1:0] wi_mag, wr_nxt, wi_nxt;

   always_comb begin
      en       = !tw.tw_valid || tw.tw_ready;
      cnt_last = (s_cnt == S_W'(LOGN - 1)) && (b_cnt == K_W'(N/2 - 1));
      issue    = (state == IDLE && start) || (state == RUN);
      k_mask   = K_W'((N >> (int'(s_cnt) + 1)) - 1);
      k_next   = K_W'((b_cnt & k_mask) << s_cnt);
      // rom_x = C[k mod N/4], rom_y = C[N/4 - k mod N/4]
      wi_mag   = p1_quad ? rom_x : rom_y;
      wr_nxt   = p1_quad ? -rom_y : rom_x;
      wi_nxt   = p1_inv ? wi_mag : -wi_mag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         s_cnt <= '0;
         b_cnt <= '0;
         inv_q <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state <= RUN;
               busy  <= 1'b1;
               inv_q <= inverse;
               b_cnt <= K_W'(1);
            end
            RUN: if (en) begin
               if (cnt_last) begin
                  state <= FLUSH;
                  s_cnt <= '0;
                  b_cnt <= '0;
               end else if (b_cnt == K_W'(N/2 - 1)) begin
                  b_cnt <= '0;
                  s_cnt <= s_cnt + S_W'(1);
               end else begin
                  b_cnt <= b_cnt + K_W'(1);
               end
            end
            FLUSH: if (tw.tw_valid && tw.tw_ready && tw.tw_last) begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p0_valid    <= 1'b0;
         p0_quad     <= 1'b0;
         p0_inv      <= 1'b0;
         p0_last     <= 1'b0;
         p0_stage    <= '0;
         p0_k        <= '0;
         p0_a        <= '0;
         p1_valid    <= 1'b0;
         p1_quad     <= 1'b0;
         p1_inv      <= 1'b0;
         p1_last     <= 1'b0;
         p1_stage    <= '0;
         p1_k        <= '0;
         rom_x       <= '0;
         rom_y       <= '0;
         tw.tw_valid <= 1'b0;
         tw.w_r      <= '0;
         tw.w_i      <= '0;
         tw.tw_stage <= '0;
         tw.tw_k     <= '0;
         tw.tw_last  <= 1'b0;
      end else if (en) begin
         p0_valid    <= issue;
         p0_stage    <= s_cnt;
         p0_k        <= k_next;
         p0_quad     <= k_next[K_W-1];
         p0_a        <= k_next[A_W-1:0];
         p0_last     <= issue && cnt_last;
         p0_inv      <= (state == IDLE) ? inverse : inv_q;

         p1_valid    <= p0_valid;
         p1_quad     <= p0_quad;
         p1_inv      <= p0_inv;
         p1_last     <= p0_last;
         p1_stage    <= p0_stage;
         p1_k        <= p0_k;
         rom_x       <= rom_rd({1'b0, p0_a});
         rom_y       <= rom_rd((A_W+1)'(Q) - {1'b0, p0_a});

         tw.tw_valid <= p1_valid;
         tw.w_r      <= wr_nxt;
         tw.w_i      <= wi_nxt;
         tw.tw_stage <= p1_stage;
         tw.tw_k     <= p1_k;
         tw.tw_last  <= p1_last;
      end
   end

endmodule

// File: tb/tb_twiddle_seq.sv
// Bench for twiddle_seq: an N=16 instance for the directed scenarios and an N=64
// instance checked against a cos/sin reference model under random back-pressure.
module tb_twiddle_seq;

   localparam int TW_W  = 10;
   localparam int SCALE = 1 << (TW_W - 2);
   localparam real PI   = 3.14159265358979323846;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, inverse, ready, sel64;
   logic start16, start64, busy16, done16, busy64, done64;

   assign start16 = start && !sel64;
   assign start64 = start && sel64;

   twiddle_if #(.N(16), .TW_W(TW_W)) tw16 ();
   twiddle_if #(.N(64), .TW_W(TW_W)) tw64 ();

   assign tw16.tw_ready = ready;
   assign tw64.tw_ready = ready;

   twiddle_seq #(.N(16), .TW_W(TW_W)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .inverse(inverse),
      .busy(busy16), .done(done16), .tw(tw16)
   );

   twiddle_seq #(.N(64), .TW_W(TW_W)) dut64 (
      .clk(clk), .rst(rst), .start(start64), .inverse(inverse),
      .busy(busy64), .done(done64), .tw(tw64)
   );

   typedef struct packed {
      int wr;
      int wi;
      int stage;
      int k;
      int last;
   } tw_t;

   typedef struct {
      int idx;
      int stage;
      int k;
      int wr;
      int wi;
   } vec_t;

   tw_t  cur;
   logic cur_valid, cur_busy, cur_done;

   always_comb begin
      cur = '0;
      if (sel64) begin
         cur_valid = tw64.tw_valid;
         cur_busy  = busy64;
         cur_done  = done64;
         cur.wr    = int'(tw64.w_r);
         cur.wi    = int'(tw64.w_i);
         cur.stage = int'(tw64.tw_stage);
         cur.k     = int'(tw64.tw_k);
         cur.last  = int'(tw64.tw_last);
      end else begin
         cur_valid = tw16.tw_valid;
         cur_busy  = busy16;
         cur_done  = done16;
         cur.wr    = int'(tw16.w_r);
         cur.wi    = int'(tw16.w_i);
         cur.stage = int'(tw16.tw_stage);
         cur.k     = int'(tw16.tw_k);
         cur.last  = int'(tw16.tw_last);
      end
   end

   tw_t  acc_q[$];
   tw_t  exp_q[$];
   vec_t vecs[14];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Output hold under stall and capture of accepted twiddles.
   logic prev_stall = 1'b0;
   logic prev_rst   = 1'b0;
   tw_t  prev_rec;

   always @(negedge clk) begin
      if (prev_stall && !prev_rst) begin
         n_tests++;
         if (cur != prev_rec) begin
            n_fail++;
            $display("FAIL stall_hold: got (%0d,%0d) s%0d k%0d, expected (%0d,%0d) s%0d k%0d",
                     cur.wr, cur.wi, cur.stage, cur.k,
                     prev_rec.wr, prev_rec.wi, prev_rec.stage, prev_rec.k);
         end
      end
      if (cur_valid && ready && !rst) acc_q.push_back(cur);
      prev_stall <= cur_valid && !ready;
      prev_rst   <= rst;
      prev_rec   <= cur;
   end

   function automatic int rnd(input real x);
      if (x >= 0.0) return int'($floor(x + 0.5));
      return -int'($floor(-x + 0.5));
   endfunction

   task automatic make_exp(input int n, input bit inv);
      int  logn;
      tw_t e;
      real ang;
      exp_q.delete();
      logn = $clog2(n);
      for (int s = 0; s < logn; s++) begin
         for (int b = 0; b < n / 2; b++) begin
            e.k     = (b % (n >> (s + 1))) * (1 << s);
            ang     = 2.0 * PI * real'(e.k) / real'(n);
            e.wr    = rnd($cos(ang) * real'(SCALE));
            e.wi    = rnd((inv ? 1.0 : -1.0) * $sin(ang) * real'(SCALE));
            e.stage = s;
            e.last  = (s == logn - 1 && b == n / 2 - 1) ? 1 : 0;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic cmp_stream(input string name);
      check({name, "_len"}, acc_q.size(), exp_q.size());
      for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (acc_q[i] != exp_q[i]) begin
            n_fail++;
            $display("FAIL %s[%0d]: got (%0d,%0d) s%0d k%0d last%0d, expected (%0d,%0d) s%0d k%0d last%0d",
                     name, i, acc_q[i].wr, acc_q[i].wi, acc_q[i].stage, acc_q[i].k, acc_q[i].last,
                     exp_q[i].wr, exp_q[i].wi, exp_q[i].stage, exp_q[i].k, exp_q[i].last);
         end
      end
   endtask

   task automatic check_table(input bit inv);
      tw_t r;
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].idx < acc_q.size()) begin
            r = acc_q[vecs[i].idx];
            check($sformatf("vec%0d_stage", i), r.stage, vecs[i].stage);
            check($sformatf("vec%0d_k", i), r.k, vecs[i].k);
            check($sformatf("vec%0d_wr", i), r.wr, vecs[i].wr);
            check($sformatf("vec%0d_wi", i), r.wi, inv ? -vecs[i].wi : vecs[i].wi);
         end else begin
            check($sformatf("vec%0d_present", i), 0, 1);
         end
      end
   endtask

   // mode 0: ready high; 1: random ready with a 10-cycle stall after 12 outputs;
   // 2: ready high, second start pulse at t=5; 3: reset after 12 outputs.
   task automatic run_seq(input bit inv, input int mode, input int m, output int n_dn);
      int t, t_done, valid_cnt, stretch, rst_t;
      bit stretch_done;
      acc_q.delete();
      n_dn = 0; t_done = -1; valid_cnt = 0; stretch = 0; stretch_done = 0; rst_t = -1; t = 0;
      @(posedge clk); #1;
      start = 1'b1; inverse = inv; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; inverse = !inv;
      while (t < 3000) begin
         @(negedge clk);
         if (t == 0) begin
            check("busy_at_E", int'(cur_busy), 1);
            check("valid_at_E", int'(cur_valid), 0);
         end
         if (t == 1) check("valid_at_E1", int'(cur_valid), 0);
         if (t == 2) check("valid_at_E2", int'(cur_valid), 1);
         if (mode == 0 && t >= 2 && t <= m + 1 && cur_valid) valid_cnt++;
         if (cur_done) begin
            n_dn++;
            if (t_done < 0) begin
               t_done = t;
               check("busy_with_done", int'(cur_busy), 0);
            end
         end
         if (mode == 3 && rst_t >= 0 && t == rst_t + 1) begin
            check("rst_valid", int'(cur_valid), 0);
            check("rst_wr", cur.wr, 0);
            check("rst_wi", cur.wi, 0);
            check("rst_stage", cur.stage, 0);
            check("rst_k", cur.k, 0);
            check("rst_last", cur.last, 0);
            check("rst_busy", int'(cur_busy), 0);
            check("rst_done", int'(cur_done), 0);
         end
         if (mode == 3 && rst_t >= 0 && t == rst_t + 8) break;
         if (t_done >= 0 && t == t_done + 3) break;
         @(posedge clk); #1;
         t++;
         start = 1'b0;
         rst   = 1'b0;
         case (mode)
            1: begin
               if (stretch > 0) begin
                  ready = 1'b0;
                  stretch--;
               end else if (!stretch_done && acc_q.size() >= 12) begin
                  ready = 1'b0;
                  stretch = 9;
                  stretch_done = 1'b1;
               end else begin
                  ready = ($urandom_range(0, 3) != 0);
               end
            end
            2: start = (t == 5);
            3: if (rst_t < 0 && acc_q.size() == 12) begin
               rst = 1'b1;
               rst_t = t;
            end
            default: ready = 1'b1;
         endcase
      end
      ready = 1'b1; start = 1'b0; rst = 1'b0;
      if (mode != 3) begin
         check("done_seen", (t_done >= 0) ? 1 : 0, 1);
         if (mode != 1) check("done_time", t_done, m + 2);
      end else begin
         check("rst_applied", (rst_t >= 0) ? 1 : 0, 1);
      end
      if (mode == 0) check("valid_run_len", valid_cnt, m);
   endtask

   int nd;

   initial begin
      vecs[0]  = '{0, 0, 0, 256, 0};
      vecs[1]  = '{1, 0, 1, 237, -98};
      vecs[2]  = '{2, 0, 2, 181, -181};
      vecs[3]  = '{3, 0, 3, 98, -237};
      vecs[4]  = '{4, 0, 4, 0, -256};
      vecs[5]  = '{5, 0, 5, -98, -237};
      vecs[6]  = '{6, 0, 6, -181, -181};
      vecs[7]  = '{7, 0, 7, -237, -98};
      vecs[8]  = '{8, 1, 0, 256, 0};
      vecs[9]  = '{9, 1, 2, 181, -181};
      vecs[10] = '{10, 1, 4, 0, -256};
      vecs[11] = '{11, 1, 6, -181, -181};
      vecs[12] = '{13, 1, 2, 181, -181};
      vecs[13] = '{31, 3, 0, 256, 0};

      sel64 = 1'b0; rst = 1'b1; start = 1'b0; inverse = 1'b0; ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid", int'(cur_valid), 0);
      check("reset_wr", cur.wr, 0);
      check("reset_wi", cur.wi, 0);
      check("reset_stage", cur.stage, 0);
      check("reset_k", cur.k, 0);
      check("reset_last", cur.last, 0);
      check("reset_busy", int'(cur_busy), 0);
      check("reset_done", int'(cur_done), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      make_exp(16, 1'b0);
      run_seq(1'b0, 0, 32, nd);
      check("fwd_done_count", nd, 1);
      cmp_stream("fwd");
      check_table(1'b0);
      if (acc_q.size() == 32) begin
         check("fwd_last31", acc_q[31].last, 1);
         check("fwd_last30", acc_q[30].last, 0);
      end else begin
         check("fwd_count", acc_q.size(), 32);
      end

      make_exp(16, 1'b1);
      run_seq(1'b1, 0, 32, nd);
      check("inv_done_count", nd, 1);
      cmp_stream("inv");
      check_table(1'b1);

      make_exp(16, 1'b0);
      run_seq(1'b0, 1, 32, nd);
      check("bp_done_count", nd, 1);
      cmp_stream("bp");

      run_seq(1'b0, 2, 32, nd);
      check("restart_done_count", nd, 1);
      cmp_stream("restart");

      run_seq(1'b0, 3, 32, nd);
      check("abort_done_count", nd, 0);
      run_seq(1'b0, 0, 32, nd);
      check("after_abort_done_count", nd, 1);
      cmp_stream("after_abort");

      @(posedge clk); #1;
      sel64 = 1'b1;
      make_exp(64, 1'b0);
      run_seq(1'b0, 1, 192, nd);
      check("n64_done_count", nd, 1);
      cmp_stream("n64_fwd");

      make_exp(64, 1'b1);
      run_seq(1'b1, 0, 192, nd);
      check("n64_inv_done_count", nd, 1);
      cmp_stream("n64_inv");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
